pc_unit: RTL and testbench

Parametrised program-counter unit for the pipelined MIPS core, replacing the plain PC register at the head of the IF stage. It holds the fetch PC and adds stall hold, branch/jump redirect, and buffering of a redirect that arrives while the stage is stalled. It also handles exception-vector entry with an internal EPC, eret return, and an address-fault flag for fetch-address range and alignment checks.

---
 rtl/pc_unit_if.sv | 27 ++
 rtl/pc_unit.sv | 87 ++++++++
 tb/tb_pc_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-PC control bundle: hazard/branch/exception controls in, PC views out.
// The master side drives the controls; pc_unit sits on the slave side.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect_en;
    logic [WIDTH-1:0] redirect_target;
    logic             exc_req;
    logic [WIDTH-1:0] exc_pc;
    logic             eret;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc_out;
    logic             redirect_pending;
    logic             addr_fault;

    modport master (
        output stall, redirect_en, redirect_target, exc_req, exc_pc, eret,
        input  pc_out, pc_plus4, epc_out, redirect_pending, addr_fault
    );

    modport slave (
        input  stall, redirect_en, redirect_target, exc_req, exc_pc, eret,
        output pc_out, pc_plus4, epc_out, redirect_pending, addr_fault
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit at the head of IF: stall hold, branch/jump redirect,
// buffering of a redirect that lands during a stall, exception entry with an
// internal EPC, eret return, and a fetch-address fault flag.
module pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
    parameter logic [WIDTH-1:0] ADDR_LO    = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] ADDR_HI    = WIDTH'(32'h0000_6FFC)
) (
    input  logic     clk,
    input  logic     reset,
    pc_unit_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] epc_reg, epc_next;
    logic [WIDTH-1:0] pend_target_reg, pend_target_next;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc_reg + FOUR;

    // State registers; reset dominates every other request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_ADDR;
            epc_reg         <= '0;
            pend_target_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            epc_reg         <= epc_next;
            pend_target_reg <= pend_target_next;
        end
    end

    // Next-PC selection, highest priority first: exception, eret, redirect
    // (taken now or buffered under stall), stall hold, buffered redirect
    // release, sequential fetch.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_inc;
        epc_next         = epc_reg;
        pend_target_next = pend_target_reg;

        if (bus.exc_req) begin
            pc_next    = EXC_VECTOR;
            epc_next   = bus.exc_pc;
            state_next = IDLE;
        end else if (bus.eret) begin
            // EPC is kept so a repeated eret returns to the same place.
            pc_next    = epc_reg;
            state_next = IDLE;
        end else if (bus.redirect_en && !bus.stall) begin
            // A fresh redirect supersedes anything still buffered.
            pc_next    = bus.redirect_target;
            state_next = IDLE;
        end else if (bus.redirect_en) begin
            // Stalled: park the target, last one seen wins.
            pc_next          = pc_reg;
            pend_target_next = bus.redirect_target;
            state_next       = PENDING;
        end else if (bus.stall) begin
            pc_next = pc_reg;
        end else if (state_reg == PENDING) begin
            pc_next    = pend_target_reg;
            state_next = IDLE;
        end
    end

    // Outputs depend only on registered state, never directly on inputs.
    assign bus.pc_out           = pc_reg;
    assign bus.pc_plus4         = pc_inc;
    assign bus.epc_out          = epc_reg;
    assign bus.redirect_pending = (state_reg == PENDING);
    assign bus.addr_fault       = (pc_reg[1:0] != 2'b00) || (pc_reg < ADDR_LO) || (pc_reg > ADDR_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a reference model predicts each cycle's
// outputs into a scoreboard queue, popped and compared after the edge. A
// second 16-bit instance covers PC wrap-around.
module tb_pc_unit;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset16 = 1'b0;

    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(32)) bus ();
    pc_unit_if #(.WIDTH(16)) bus16 ();

    pc_unit #(
        .WIDTH      (32),
        .RESET_ADDR (32'h0000_3000),
        .EXC_VECTOR (32'h0000_4180),
        .ADDR_LO    (32'h0000_3000),
        .ADDR_HI    (32'h0000_6FFC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pc_unit #(
        .WIDTH      (16),
        .RESET_ADDR (16'hFFF8),
        .EXC_VECTOR (16'h0180),
        .ADDR_LO    (16'h0000),
        .ADDR_HI    (16'hFFFC)
    ) dut16 (
        .clk   (clk),
        .reset (reset16),
        .bus   (bus16)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        pend;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model state
    logic [31:0] m_pc, m_epc, m_pt;
    logic        m_pv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic fault_of(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
    endfunction

    // One clock: drive inputs, predict, let the edge pass, compare.
    task automatic cycle(input logic rst, input logic st, input logic re, input logic [31:0] rt,
                         input logic ex, input logic [31:0] ep, input logic er);
        exp_t e;
        reset               = rst;
        bus.stall           = st;
        bus.redirect_en     = re;
        bus.redirect_target = rt;
        bus.exc_req         = ex;
        bus.exc_pc          = ep;
        bus.eret            = er;

        if (rst) begin
            m_pc = 32'h0000_3000; m_epc = '0; m_pt = '0; m_pv = 1'b0;
        end else if (ex) begin
            m_pc = 32'h0000_4180; m_epc = ep; m_pv = 1'b0;
        end else if (er) begin
            m_pc = m_epc; m_pv = 1'b0;
        end else if (re && !st) begin
            m_pc = rt; m_pv = 1'b0;
        end else if (re && st) begin
            m_pt = rt; m_pv = 1'b1;
        end else if (st) begin
            // hold
        end else if (m_pv) begin
            m_pc = m_pt; m_pv = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.epc = m_epc; e.pend = m_pv; e.fault = fault_of(m_pc);
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d pc=0x%08h exp=0x%08h epc=0x%08h pend=%0b fault=%0b", txn,
                 bus.pc_out, e.pc, bus.epc_out, bus.redirect_pending, bus.addr_fault);
        chk("pc_out", bus.pc_out, e.pc);
        chk("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
        chk("epc_out", bus.epc_out, e.epc);
        chk("redirect_pending", {31'd0, bus.redirect_pending}, {31'd0, e.pend});
        chk("addr_fault", {31'd0, bus.addr_fault}, {31'd0, e.fault});
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        bus.stall = 0; bus.redirect_en = 0; bus.redirect_target = 0;
        bus.exc_req = 0; bus.exc_pc = 0; bus.eret = 0;
        bus16.stall = 0; bus16.redirect_en = 0; bus16.redirect_target = 0;
        bus16.exc_req = 0; bus16.exc_pc = 0; bus16.eret = 0;
        reset16 = 1'b1;
        @(posedge clk); #1;

        // Reset then free-running fetch
        cycle(1'b1, 0, 0, 0, 0, 0, 0);
        chk("reset_pc", bus.pc_out, 32'h0000_3000);
        chk("reset_epc", bus.epc_out, 32'h0);
        idle_cycle();
        idle_cycle();
        chk("seq_pc", bus.pc_out, 32'h0000_3008);

        // Stall hold for two cycles, then release
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        chk("stall_hold", bus.pc_out, 32'h0000_3008);
        idle_cycle();
        chk("stall_release", bus.pc_out, 32'h0000_300C);
        idle_cycle();

        // Redirect buffered across a stall, last target wins
        cycle(0, 1, 1, 32'h0000_3100, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 32'h0000_3200, 0, 0, 0);
        chk("pend_hold_pc", bus.pc_out, 32'h0000_3010);
        idle_cycle();
        chk("pend_release", bus.pc_out, 32'h0000_3200);

        // Exception beats stall and redirect; eret returns to EPC
        cycle(0, 0, 1, 32'h0000_3020, 0, 0, 0);
        cycle(0, 1, 1, 32'h0000_3500, 1, 32'h0000_301C, 0);
        chk("exc_vector", bus.pc_out, 32'h0000_4180);
        idle_cycle();
        cycle(0, 1, 1, 32'h0000_3600, 0, 0, 1);
        chk("eret_pc", bus.pc_out, 32'h0000_301C);
        chk("eret_keeps_epc", bus.epc_out, 32'h0000_301C);

        // Exception clears a pending redirect; exc beats eret
        cycle(0, 1, 1, 32'h0000_3700, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h0000_3444, 1);
        chk("exc_over_eret_epc", bus.epc_out, 32'h0000_3444);
        idle_cycle();

        // Address-fault boundaries
        cycle(0, 0, 1, 32'h0000_3002, 0, 0, 0);
        idle_cycle();
        cycle(0, 0, 1, 32'h0000_7000, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_2FFC, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_6FFC, 0, 0, 0);
        chk("fault_hi_edge", {31'd0, bus.addr_fault}, 32'd0);
        idle_cycle();
        chk("fault_past_hi", {31'd0, bus.addr_fault}, 32'd1);

        // Reset while a redirect is pending discards it
        cycle(0, 1, 1, 32'h0000_5000, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        chk("reset_pend_clear", {31'd0, bus.redirect_pending}, 32'd0);
        idle_cycle();
        chk("reset_target_gone", bus.pc_out, 32'h0000_3004);

        // Random mix of all controls
        for (int i = 0; i < 150; i++) begin
            logic [31:0] rt;
            rt = 32'h0000_2FF0 + 32'($urandom_range(0, 32'h4020));
            cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), rt, ($urandom_range(0, 15) == 0),
                  32'h0000_3000 + 32'($urandom_range(0, 32'h1000)), ($urandom_range(0, 12) == 0));
        end

        // 16-bit instance: wrap-around modulo 2^WIDTH
        reset16 = 1'b1;
        @(posedge clk); #1;
        reset16 = 1'b0;
        chk("w16_reset", {16'd0, bus16.pc_out}, 32'h0000_FFF8);
        chk("w16_fault", {31'd0, bus16.addr_fault}, 32'd0);
        @(posedge clk); #1;
        chk("w16_pc1", {16'd0, bus16.pc_out}, 32'h0000_FFFC);
        chk("w16_plus4", {16'd0, bus16.pc_plus4}, 32'h0000_0000);
        @(posedge clk); #1;
        chk("w16_wrap", {16'd0, bus16.pc_out}, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
